// File: rtl/seven_segment_control_n.sv
// Multiplexed N-digit seven-segment driver with dead time, PWM brightness,
// per-digit blink, leading-zero suppression and frame-synchronous shadow registers.
module seven_segment_control_n #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_BITS   = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   digit_display,
    input  logic [NUM_DIGITS-1:0]   digit_point,
    input  logic [NUM_DIGITS-1:0]   digit_blink,
    input  logic                    zero_suppress,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int SLOT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW     = SLOT_W + 6;
    localparam logic [CW-1:0]     ACTIVE    = CW'(DIGIT_CYCLES - BLANK_CYCLES);
    localparam logic [CW-1:0]     BLANK     = CW'(BLANK_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [BLINK_BITS-1:0]   blink_cnt;
    logic [4*NUM_DIGITS-1:0] data_sh;
    logic [NUM_DIGITS-1:0]   display_sh, point_sh, blink_sh;
    logic                    zs_sh;
    logic [3:0]              bright_sh;

    logic                    load, slot_start;
    logic [4*NUM_DIGITS-1:0] data_eff;
    logic [NUM_DIGITS-1:0]   display_eff, point_eff, blink_eff;
    logic                    zs_eff;
    logic [3:0]              bright_eff;
    logic [CW-1:0]           on_cycles, slot_ext;
    logic                    in_window, lit;
    logic [3:0]              nibble;
    logic                    cur_display, cur_point, cur_blink, suppressed, upper_zero;
    logic [NUM_DIGITS-1:0]   onehot;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign slot_start = (slot_cnt == '0);
    assign load       = slot_start && (digit_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sh    <= '0;
            display_sh <= '0;
            point_sh   <= '0;
            blink_sh   <= '0;
            zs_sh      <= 1'b0;
            bright_sh  <= '0;
        end else begin
            if (load) begin
                data_sh    <= data_in;
                display_sh <= digit_display;
                point_sh   <= digit_point;
                blink_sh   <= digit_blink;
                zs_sh      <= zero_suppress;
            end
            if (slot_start) bright_sh <= brightness;
        end
    end

    // In the load cycle the incoming values are used directly so a zero-length
    // dead time still shows the new frame from its very first cycle.
    assign data_eff    = load ? data_in       : data_sh;
    assign display_eff = load ? digit_display : display_sh;
    assign point_eff   = load ? digit_point   : point_sh;
    assign blink_eff   = load ? digit_blink   : blink_sh;
    assign zs_eff      = load ? zero_suppress : zs_sh;
    assign bright_eff  = slot_start ? brightness : bright_sh;

    assign on_cycles = (ACTIVE * ({{(CW-4){1'b0}}, bright_eff} + CW'(1))) >> 4;
    assign slot_ext  = CW'(slot_cnt);
    assign in_window = (slot_ext >= BLANK) && (slot_ext < BLANK + on_cycles);

    // Scan from the top digit down so upper_zero reflects this digit and all above it.
    always_comb begin
        nibble      = '0;
        cur_display = 1'b0;
        cur_point   = 1'b0;
        cur_blink   = 1'b0;
        suppressed  = 1'b0;
        onehot      = '0;
        upper_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (data_eff[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                nibble      = data_eff[4*i +: 4];
                cur_display = display_eff[i];
                cur_point   = point_eff[i];
                cur_blink   = blink_eff[i];
                suppressed  = zs_eff && (i != 0) && upper_zero;
                onehot[i]   = 1'b1;
            end
        end
    end

    assign lit = in_window && cur_display && !(cur_blink && blink_cnt[BLINK_BITS-1]) && !suppressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode      <= '1;
            segment    <= 7'b1111111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            anode      <= lit ? ~onehot : '1;
            segment    <= lit ? hex7(nibble) : 7'b1111111;
            dp         <= lit ? ~cur_point : 1'b1;
            frame_tick <= load;
        end
    end

endmodule

// File: tb/tb_seven_segment_control_n.sv
// Scoreboard bench for seven_segment_control_n: a cycle model indexed by time
// since reset release pushes expected outputs, popped and compared at negedge.
module tb_seven_segment_control_n;

    localparam int ND = 4;
    localparam int DC = 32;
    localparam int BC = 4;
    localparam int BB = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in;
    logic [3:0]  digit_display, digit_point, digit_blink, brightness;
    logic        zero_suppress;
    logic [3:0]  anode;
    logic [6:0]  segment;
    logic        dp, frame_tick;

    always #5 clk = ~clk;

    seven_segment_control_n #(
        .NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_BITS(BB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .digit_display(digit_display),
        .digit_point(digit_point), .digit_blink(digit_blink), .zero_suppress(zero_suppress),
        .brightness(brightness), .anode(anode), .segment(segment), .dp(dp),
        .frame_tick(frame_tick)
    );

    typedef logic [12:0] outv_t;   // {anode, segment, dp, frame_tick}
    outv_t exp_q[$];

    int vectors = 0;
    int errs = 0;
    int mt = 0;
    int cyc = 0;
    int last_ft = -1;
    int lowcnt = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_disp = '0, m_pt = '0, m_blk = '0, m_br = '0;
    logic        m_zs = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_step();
        outv_t e;
        int slot, d, on;
        logic ph, lit, ft;
        if (!rst_n) begin
            e = {4'hF, 7'h7F, 1'b1, 1'b0};
            mt = 0;
            m_data = '0; m_disp = '0; m_pt = '0; m_blk = '0; m_br = '0; m_zs = 1'b0;
        end else begin
            slot = mt % DC;
            d    = (mt / DC) % ND;
            ph   = ((mt % (1 << BB)) >= (1 << (BB - 1)));
            ft   = (slot == 0) && (d == 0);
            if (ft) begin
                m_data = data_in; m_disp = digit_display; m_pt = digit_point;
                m_blk = digit_blink; m_zs = zero_suppress;
            end
            if (slot == 0) m_br = brightness;
            on  = ((DC - BC) * (int'(m_br) + 1)) / 16;
            lit = (slot >= BC) && (slot < BC + on) && m_disp[d] && !(m_blk[d] && ph)
                  && !(m_zs && d > 0 && (m_data >> (4 * d)) == 16'h0);
            if (lit) e = {~(4'b0001 << d), seg_of(m_data[4*d +: 4]), ~m_pt[d], ft};
            else     e = {4'hF, 7'h7F, 1'b1, ft};
            mt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        outv_t e, o;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e = exp_q.pop_front();
        o = {anode, segment, dp, frame_tick};
        check("outputs", 32'(o), 32'(e));
        if (anode != 4'hF) lowcnt++;
        if (frame_tick) begin
            if (last_ft >= 0) check("frame_period", cyc - last_ft, 128);
            last_ft = cyc;
        end
    endtask

    initial begin
        data_in = 16'h1234; digit_display = 4'hF; digit_point = 4'h0;
        digit_blink = 4'h0; zero_suppress = 1'b0; brightness = 4'd15;

        repeat (3) tick();
        check("reset_anode", anode, 4'hF);
        check("reset_segment", segment, 7'h7F);
        rst_n = 1'b1;
        last_ft = -1;
        repeat (256) tick();

        brightness = 4'd7; lowcnt = 0;
        repeat (128) tick();
        check("on_cycles_b7", lowcnt, 56);
        brightness = 4'd0; lowcnt = 0;
        repeat (128) tick();
        check("on_cycles_b0", lowcnt, 4);
        lowcnt = 0;
        repeat (10) tick();
        brightness = 4'd15;
        repeat (118) tick();
        check("on_cycles_mid_slot_change", lowcnt, 85);

        zero_suppress = 1'b1; data_in = 16'h0050;
        repeat (128) tick();
        data_in = 16'h0000;
        repeat (128) tick();

        zero_suppress = 1'b0; data_in = 16'h1234;
        digit_blink = 4'b0100; digit_point = 4'b0001;
        repeat (256) tick();
        digit_blink = 4'b1010;
        repeat (256) tick();
        digit_blink = 4'b0000; digit_point = 4'b0000;

        repeat (40) tick();
        data_in = 16'hABCD;
        repeat (216) tick();

        repeat (12) tick();
        check("prereset_lit_anode", anode, 4'hE);
        #2 rst_n = 1'b0;
        #1;
        check("async_anode", anode, 4'hF);
        check("async_segment", segment, 7'h7F);
        check("async_dp", dp, 1'b1);
        repeat (3) tick();
        rst_n = 1'b1;
        last_ft = -1;
        repeat (160) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
